// File: rtl/fpdiv_arbiter.sv
// Two-requester round-robin front end for a shared floating-point divider.
// Handles zero divisors locally, bounds divider latency with a timeout, flushes stale divides after reset.
module fpdiv_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] y0,
  input  logic [31:0] y1,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] q,
  output logic        dz,
  output logic        err,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_y,
  output logic [31:0] div_x,
  input  logic        div_done,
  input  logic [31:0] div_q
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg;
  logic          rr_reg;
  logic          gidx_reg;
  logic [CW-1:0] cnt_reg;

  logic          gnt;
  logic [31:0]   gy;
  logic [31:0]   gx;

  // rr only breaks ties; a lone requester always wins.
  always_comb begin
    gnt = (req0 && req1) ? rr_reg : req1;
    gy  = gnt ? y1 : y0;
    gx  = gnt ? x1 : x0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= DRAIN;
      rr_reg    <= 1'b0;
      gidx_reg  <= 1'b0;
      cnt_reg   <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      q         <= '0;
      dz        <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b1;
      div_start <= 1'b0;
      div_y     <= '0;
      div_x     <= '0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      div_start <= 1'b0;
      case (state_reg)
        DRAIN: begin
          if (div_done || cnt_reg == LAST) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        IDLE: begin
          if (req0 || req1) begin
            gidx_reg <= gnt;
            rr_reg   <= ~gnt;
            div_y    <= gy;
            div_x    <= gx;
            busy     <= 1'b1;
            // Zero exponent (zero or subnormal divisor) answers immediately with signed infinity.
            if (gx[30:23] == 8'h00) begin
              q         <= {gy[31] ^ gx[31], 8'hFF, 23'd0};
              dz        <= 1'b1;
              err       <= 1'b0;
              ack0      <= ~gnt;
              ack1      <= gnt;
              state_reg <= RESP;
            end else begin
              div_start <= 1'b1;
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            q         <= div_q;
            dz        <= 1'b0;
            err       <= 1'b0;
            ack0      <= ~gidx_reg;
            ack1      <= gidx_reg;
            state_reg <= RESP;
          end else if (cnt_reg == LAST) begin
            q         <= '0;
            dz        <= 1'b0;
            err       <= 1'b1;
            ack0      <= ~gidx_reg;
            ack1      <= gidx_reg;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= DRAIN;
          cnt_reg   <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Randomized bench for fpdiv_arbiter: a transaction-level model predicts grant order, response
// timing and results from requester state and the divider latency the bench chooses per request.
module tb_fpdiv_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] y0 = '0, y1 = '0, x0 = '0, x1 = '0;
  logic        ack0, ack1, dz, err, busy, div_start;
  logic [31:0] q, div_y, div_x;
  logic        div_done = 1'b0;
  logic [31:0] div_q = '0;

  always #5 clk = ~clk;

  fpdiv_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .y0(y0), .y1(y1), .x0(x0), .x1(x1),
    .ack0(ack0), .ack1(ack1), .q(q), .dz(dz), .err(err), .busy(busy),
    .div_start(div_start), .div_y(div_y), .div_x(div_x),
    .div_done(div_done), .div_q(div_q)
  );

  int checks = 0, errors = 0, cyc = 0;

  // requester state
  bit          pend [2];
  logic [31:0] opy [2];
  logic [31:0] opx [2];

  // model of the arbiter at transaction level
  int          free_at, issue_at, done_at;
  bit          m_rr, m_drain;
  bit          rv, r_idx, r_dz, r_err;
  int          r_ack;
  logic [31:0] r_q;
  logic [31:0] cur_q, exp_dy, exp_dx;
  bit          cur_dz, cur_err;
  int          plan_k [$];

  // scenario controls
  bit rst_cmd, stale_cmd, hold_mode, checks_on;
  int p_new, acks_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %08h want %08h", tag, cyc, got, want);
    end
  endtask

  function automatic real sp2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'h00) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic s;
    real  a;
    int   e, m;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {s, 31'd0};
    e = 127;
    while (a >= 2.0 && e < 254) begin a = a / 2.0; e++; end
    while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 8388608.0);
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (b[30:23] == 8'h00) return 32'h7FC00000;
    return r2sp(sp2r(a) / sp2r(b));
  endfunction

  // Operands chosen so the quotient is exact: divisor is a power of two or has a zero exponent.
  task automatic new_req(input int n);
    logic [31:0] r1, r2;
    r1 = $urandom();
    r2 = $urandom();
    opy[n] = {r1[31], 8'(110 + $urandom_range(0, 35)), r1[22:0]};
    if ($urandom_range(0, 99) < 15) opx[n] = {r2[31], 8'h00, r2[22:0]};
    else                            opx[n] = {r2[31], 8'(110 + $urandom_range(0, 35)), 23'd0};
    pend[n] = 1'b1;
  endtask

  task automatic model_reset();
    rv = 0; issue_at = -1; done_at = -1; m_rr = 0; m_drain = 1;
    cur_q = '0; cur_dz = 0; cur_err = 0; exp_dy = '0; exp_dx = '0;
    free_at = cyc + 1 + T;
    checks_on = 1;
  endtask

  task automatic model_grant();
    bit g;
    int k;
    g = (pend[0] && pend[1]) ? m_rr : pend[1];
    m_rr = !g; m_drain = 0;
    exp_dy = opy[g]; exp_dx = opx[g];
    rv = 1; r_idx = g; r_dz = 0; r_err = 0;
    if (opx[g][30:23] == 8'h00) begin
      r_q = {opy[g][31] ^ opx[g][31], 8'hFF, 23'd0};
      r_dz = 1; r_ack = cyc + 1; issue_at = -1; done_at = -1;
    end else begin
      if (plan_k.size() > 0) k = plan_k.pop_front();
      else begin
        k = $urandom_range(0, 99);
        k = (k < 10) ? T : (k < 20) ? T - 1 : int'($urandom_range(0, 5));
      end
      issue_at = cyc + 1;
      if (k < T) begin
        done_at = cyc + 2 + k; r_ack = cyc + 3 + k; r_q = fdiv(opy[g], opx[g]);
      end else begin
        done_at = -1; r_ack = cyc + 2 + T; r_q = '0; r_err = 1;
      end
    end
    free_at = r_ack + 1;
  endtask

  // One clock: check outputs of this cycle, then drive inputs sampled at the next rising edge.
  task automatic step();
    logic [1:0] ack_exp;
    @(negedge clk);
    cyc++;
    if (checks_on) begin
      ack_exp = 2'b00;
      if (rv && cyc == r_ack) begin
        cur_q = r_q; cur_dz = r_dz; cur_err = r_err;
        ack_exp = r_idx ? 2'b10 : 2'b01;
      end
      check("ack",       32'({ack1, ack0}), 32'(ack_exp));
      check("q",         q, cur_q);
      check("dz",        32'(dz), 32'(cur_dz));
      check("err",       32'(err), 32'(cur_err));
      check("busy",      32'(busy), 32'(cyc < free_at));
      check("div_start", 32'(div_start), 32'(cyc == issue_at));
      check("div_y",     div_y, exp_dy);
      check("div_x",     div_x, exp_dx);
      if (rv && cyc == r_ack) begin
        rv = 0; pend[r_idx] = 0; acks_seen++;
        if (hold_mode) new_req(int'(r_idx));
      end
    end
    for (int n = 0; n < 2; n++)
      if (!pend[n] && $urandom_range(0, 99) < p_new) new_req(n);
    reset = rst_cmd;
    req0 = pend[0]; req1 = pend[1];
    y0 = opy[0]; x0 = opx[0]; y1 = opy[1]; x1 = opx[1];
    if (!rst_cmd && cyc == done_at) begin
      div_done = 1'b1; div_q = fdiv(div_y, div_x);
    end else if (stale_cmd) begin
      div_done = 1'b1; div_q = $urandom();
    end else begin
      div_done = 1'b0; div_q = 32'hDEADBEEF;
    end
    if (rst_cmd) model_reset();
    else begin
      if (cyc >= free_at) m_drain = 0;
      if (div_done && m_drain && cyc < free_at) free_at = cyc + 1;
      if (cyc >= free_at && (pend[0] || pend[1])) model_grant();
    end
  endtask

  task automatic run_until_quiet(input int max_cycles);
    int i;
    i = 0;
    while (i < max_cycles && (pend[0] || pend[1] || rv)) begin step(); i++; end
    check("quiet_bound", 32'(pend[0] || pend[1] || rv), 32'd0);
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0; opy[0] = '0; opy[1] = '0; opx[0] = '0; opx[1] = '0;
    free_at = 1 << 30; issue_at = -1; done_at = -1; rv = 0;
    rst_cmd = 1; stale_cmd = 0; hold_mode = 0; checks_on = 0; p_new = 0; acks_seen = 0;

    repeat (3) step();
    rst_cmd = 0;
    repeat (T + 4) step();                       // drain with no div_done, then idle

    opy[0] = 32'h40C00000; opx[0] = 32'h40000000; pend[0] = 1; plan_k.push_back(3);
    run_until_quiet(100);                        // 6.0 / 2.0

    opy[1] = 32'hC0000000; opx[1] = 32'h00000000; pend[1] = 1;
    run_until_quiet(100);                        // divide by zero

    hold_mode = 1; acks_seen = 0;
    new_req(0); new_req(1);
    for (int i = 0; i < 600 && acks_seen < 8; i++) step();
    hold_mode = 0;
    check("hold_acks", 32'(acks_seen >= 8), 32'd1);
    run_until_quiet(200);

    opy[0] = 32'h41200000; opx[0] = 32'h3F800000; pend[0] = 1; plan_k.push_back(T);
    run_until_quiet(100);                        // full timeout
    opy[1] = 32'h41200000; opx[1] = 32'h40800000; pend[1] = 1; plan_k.push_back(T - 1);
    run_until_quiet(100);                        // done on last timeout cycle

    opy[0] = 32'h41200000; opx[0] = 32'h40800000; pend[0] = 1; plan_k.push_back(T);
    repeat (6) step();                           // now mid-WAIT
    rst_cmd = 1; repeat (2) step(); rst_cmd = 0;
    repeat (3) step();
    stale_cmd = 1; step(); stale_cmd = 0;        // stale completion during DRAIN
    plan_k.push_back(2);
    run_until_quiet(100);

    p_new = 30;
    repeat (1500) step();
    p_new = 0;
    run_until_quiet(200);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpdiv_arbiter.md
FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT-state cycles allowed before an error response.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester n; held high until ackn.
REQ-005 y0, y1  input  32 each  requester n dividend, IEEE-754 single.
REQ-006 x0, x1  input  32 each  requester n divisor, IEEE-754 single.
REQ-007 ack0, ack1  output  1 each  one-cycle response strobe to requester n.
REQ-008 q  output  32  quotient y/x; valid while ack0|ack1, held until the next response.
REQ-009 dz  output  1  divide-by-zero flag; valid with q.
REQ-010 err  output  1  timeout flag; valid with q.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 div_start  output  1  start pulse to the shared FP divider.
REQ-013 div_y, div_x  output  32 each  registered operands to the divider's Y and X inputs.
REQ-014 div_done  input  1  divider completion pulse.
REQ-015 div_q  input  32  divider result; valid when div_done is high.

Function
REQ-016 States: DRAIN, IDLE, ISSUE, WAIT, RESP; all outputs are registered.
REQ-017 DRAIN: wait until div_done or TIMEOUT cycles have elapsed, then go to IDLE; no grant is made in DRAIN, which flushes any divide left running across reset.
REQ-018 IDLE, neither request high: remain in IDLE.
REQ-019 IDLE, any request high: grant one requester, latch its y/x into div_y/div_x, record the grant index, and update the round-robin pointer.
REQ-020 Round-robin pointer rr: when both requests are high, grant requester rr; after any grant to n, rr becomes ~n.
REQ-021 Zero-divisor check in IDLE: if the granted x[30:23]==0, set q={y[31]^x[31],8'hFF,23'd0}, dz=1, err=0 and go directly to RESP; the divider is not started.
REQ-022 Otherwise go to ISSUE: div_start=1 for exactly one cycle, then go to WAIT.
REQ-023 div_y/div_x are stable from the ISSUE cycle until the next grant.
REQ-024 WAIT: a cycle counter starts at 0 and increments each WAIT cycle.
REQ-025 WAIT, div_done high: capture q=div_q with dz=0, err=0 and go to RESP.
REQ-026 WAIT, counter reaches TIMEOUT-1 without div_done: set q=0, err=1, dz=0 and go to RESP.
REQ-027 div_done on the timeout cycle: div_done wins and err stays 0.
REQ-028 RESP: assert ackn for the recorded grant index for one cycle, then go to IDLE; ack0 and ack1 are never high together.
REQ-029 A requester drops req in the cycle after its ack; a req still high in that IDLE cycle is treated as a new request.
REQ-030 div_done outside WAIT/DRAIN is ignored.
REQ-031 Requests arriving while busy are not lost: req remains high and is arbitrated at the next IDLE.
REQ-032 Non-zero-divisor latency: grant (IDLE) -> ISSUE +1 -> div_done captured in WAIT -> ack on the following cycle.
REQ-033 Zero-divisor latency: ack is asserted 1 cycle after the grant cycle.
REQ-034 The WAIT counter is wide enough for TIMEOUT; it is cleared on entry to WAIT and on entry to DRAIN.

Reset
REQ-035 Reset asserted: next state is DRAIN; rr=0; counter=0.
REQ-036 Reset values: ack0, ack1, div_start, dz, err = 0; q, div_y, div_x = 0; busy=1 (DRAIN).
REQ-037 Reset takes priority over every transition, including reset in ISSUE, WAIT or RESP; a pending ack is dropped.

Verification
REQ-038 Reset, then idle for TIMEOUT cycles with no div_done -> busy falls after TIMEOUT cycles; state is IDLE.
REQ-039 req0 with y0=0x40C00000, x0=0x40000000 and a divider model -> one div_start pulse; ack0 with q=0x40400000, dz=0, err=0.
REQ-040 req1 with y1=0xC0000000, x1=0x00000000 -> ack1 1 cycle after grant; q=0xFF800000, dz=1; div_start never asserted.
REQ-041 req0 and req1 high together, held across repeated requests -> grants alternate 0,1,0,1 starting from rr=0; ack0 and ack1 are never high together.
REQ-042 Divider model withholds div_done -> after TIMEOUT WAIT cycles, ack with q=0, err=1; a separate case with div_done on the last timeout cycle gives err=0.
REQ-043 Reset pulsed mid-WAIT, then stale div_done delivered during DRAIN -> no ack; IDLE is reached; the next request completes normally.
